// File: rtl/sda_kernel_ctrl_multi.sv
// rtl/sda_kernel_ctrl_multi.sv - multi-channel kernel run/status register block
//
// Ports:
//   ap_clk, ap_rst_n        clock and synchronous active-low reset
//   reg_req, reg_write_en   register access strobe and direction
//   reg_addr, reg_wdata     byte address and write data
//   reg_wstrb               byte enables
//   reg_ack, reg_rdata      one-cycle ack one cycle after reg_req; rdata valid with ack, else 0
//   go_valid, go_stop       per-channel run request and its backpressure
//   done_valid, done_stop   per-channel completion and its backpressure
//   interrupt               registered level interrupt
module sda_kernel_ctrl_multi #(
  parameter int NumChannels = 1,
  parameter int AddrWidth   = 7,
  parameter int BaseAddr    = 0
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   reg_req,
  output logic                   reg_ack,
  input  logic                   reg_write_en,
  input  logic [AddrWidth-1:0]   reg_addr,
  input  logic [31:0]            reg_wdata,
  input  logic [3:0]             reg_wstrb,
  output logic [31:0]            reg_rdata,
  output logic [NumChannels-1:0] go_valid,
  input  logic [NumChannels-1:0] go_stop,
  input  logic [NumChannels-1:0] done_valid,
  output logic [NumChannels-1:0] done_stop,
  output logic                   interrupt
);

  localparam logic [AddrWidth-1:0] BaseVec = AddrWidth'(BaseAddr);

  localparam logic [2:0] OffCtrl  = 3'd0;
  localparam logic [2:0] OffGie   = 3'd1;
  localparam logic [2:0] OffIer   = 3'd2;
  localparam logic [2:0] OffIsr   = 3'd3;
  localparam logic [2:0] OffMask  = 3'd4;
  localparam logic [2:0] OffCdone = 3'd5;
  localparam logic [2:0] OffCount = 3'd6;

  typedef enum logic [1:0] {
    TOP_IDLE     = 2'd0,
    TOP_RUN      = 2'd1,
    TOP_COMPLETE = 2'd2
  } top_state_e;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_GO   = 2'd1,
    CH_BUSY = 2'd2,
    CH_DONE = 2'd3
  } ch_state_e;

  // Accepted access, held for the ack cycle; writes commit at the end of it.
  logic                   acc_q, acc_d;
  logic                   acc_we_q, acc_we_d;
  logic [2:0]             acc_off_q, acc_off_d;
  logic [31:0]            acc_wdata_q, acc_wdata_d;
  logic [3:0]             acc_wstrb_q, acc_wstrb_d;

  top_state_e             top_q, top_d;
  ch_state_e              ch_q [NumChannels];
  ch_state_e              ch_d [NumChannels];

  logic                   done_bit_q, done_bit_d;
  logic                   ready_bit_q, ready_bit_d;
  logic                   auto_q, auto_d;
  logic                   gie_q, gie_d;
  logic [1:0]             ier_q, ier_d;
  logic [1:0]             isr_q, isr_d;
  logic [NumChannels-1:0] mask_q, mask_d;
  logic [NumChannels-1:0] chan_done_q, chan_done_d;
  logic [31:0]            run_count_q, run_count_d;
  logic                   interrupt_q, interrupt_d;

  logic                   hit;
  logic                   wr, rd;
  logic                   running;
  logic                   launch;
  logic                   complete;
  logic [31:0]            wmask;
  logic [NumChannels-1:0] ch_fin;
  logic [31:0]            rdata_mux;
  logic                   unused_bits;

  assign hit     = reg_req && (reg_addr[AddrWidth-1:5] == BaseVec[AddrWidth-1:5]);
  assign wr      = acc_q && acc_we_q;
  assign rd      = acc_q && !acc_we_q;
  assign running = (top_q != TOP_IDLE);
  assign wmask   = {{8{acc_wstrb_q[3]}}, {8{acc_wstrb_q[2]}},
                    {8{acc_wstrb_q[1]}}, {8{acc_wstrb_q[0]}}};

  assign unused_bits = ^{acc_wdata_q, wmask, reg_addr[1:0]};

  always_comb begin
    acc_d       = hit;
    acc_we_d    = reg_write_en;
    acc_off_d   = reg_addr[4:2];
    acc_wdata_d = reg_wdata;
    acc_wstrb_d = reg_wstrb;
  end

  // A channel counts as finished if unmasked, already done, or accepting
  // its done this cycle; the latter lets COMPLETE follow the last done
  // acceptance directly.
  always_comb begin
    ch_fin = '0;
    for (int i = 0; i < NumChannels; i++) begin
      ch_fin[i] = !mask_q[i] || (ch_q[i] == CH_DONE) ||
                  ((ch_q[i] == CH_BUSY) && done_valid[i]);
    end
  end

  always_comb begin
    top_d    = top_q;
    launch   = 1'b0;
    complete = 1'b0;
    case (top_q)
      TOP_IDLE: begin
        if (wr && (acc_off_q == OffCtrl) && acc_wstrb_q[0] && acc_wdata_q[0]) begin
          launch = 1'b1;
          top_d  = TOP_RUN;
        end
      end
      TOP_RUN: begin
        if (&ch_fin) begin
          top_d = TOP_COMPLETE;
        end
      end
      TOP_COMPLETE: begin
        complete = 1'b1;
        if (auto_q) begin
          launch = 1'b1;
          top_d  = TOP_RUN;
        end else begin
          top_d = TOP_IDLE;
        end
      end
      default: top_d = TOP_IDLE;
    endcase
  end

  always_comb begin
    go_valid    = '0;
    done_stop   = '1;
    chan_done_d = launch ? '0 : chan_done_q;
    for (int i = 0; i < NumChannels; i++) begin
      ch_d[i] = ch_q[i];
      case (ch_q[i])
        CH_IDLE: begin
          if (launch && mask_q[i]) ch_d[i] = CH_GO;
        end
        CH_GO: begin
          go_valid[i] = 1'b1;
          if (!go_stop[i]) ch_d[i] = CH_BUSY;
        end
        CH_BUSY: begin
          done_stop[i] = 1'b0;
          if (done_valid[i]) begin
            ch_d[i]        = CH_DONE;
            chan_done_d[i] = 1'b1;
          end
        end
        CH_DONE: begin
          // An auto-restart relaunches straight out of CH_DONE.
          if (launch && mask_q[i]) begin
            ch_d[i] = CH_GO;
          end else if (top_q != TOP_RUN) begin
            ch_d[i] = CH_IDLE;
          end
        end
        default: ch_d[i] = CH_IDLE;
      endcase
    end
  end

  // Hardware set events are applied after clear-on-read and toggle writes
  // so that a coincident event is never lost.
  always_comb begin
    done_bit_d  = done_bit_q;
    ready_bit_d = ready_bit_q;
    auto_d      = auto_q;
    gie_d       = gie_q;
    ier_d       = ier_q;
    isr_d       = isr_q;
    mask_d      = mask_q;
    run_count_d = run_count_q + {31'd0, complete};
    interrupt_d = gie_q && |(ier_q & isr_q);

    if (rd && (acc_off_q == OffCtrl)) begin
      done_bit_d  = 1'b0;
      ready_bit_d = 1'b0;
    end
    if (wr && acc_wstrb_q[0]) begin
      case (acc_off_q)
        OffCtrl: auto_d = acc_wdata_q[7];
        OffGie:  gie_d  = acc_wdata_q[0];
        OffIer:  ier_d  = acc_wdata_q[1:0];
        OffIsr:  isr_d  = isr_q ^ acc_wdata_q[1:0];
        default: ;
      endcase
    end
    if (wr && (acc_off_q == OffMask) && !running) begin
      mask_d = (mask_q & ~wmask[NumChannels-1:0]) |
               (acc_wdata_q[NumChannels-1:0] & wmask[NumChannels-1:0]);
    end
    if (complete) begin
      done_bit_d = 1'b1;
      isr_d[0]   = 1'b1;
    end
    if (launch) begin
      ready_bit_d = 1'b1;
      isr_d[1]    = 1'b1;
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (acc_off_q)
      OffCtrl:  rdata_mux = {24'd0, auto_q, 3'd0, ready_bit_q, !running, done_bit_q, running};
      OffGie:   rdata_mux = {31'd0, gie_q};
      OffIer:   rdata_mux = {30'd0, ier_q};
      OffIsr:   rdata_mux = {30'd0, isr_q};
      OffMask:  rdata_mux = 32'(mask_q);
      OffCdone: rdata_mux = 32'(chan_done_q);
      OffCount: rdata_mux = run_count_q;
      default:  rdata_mux = '0;
    endcase
  end

  assign reg_ack   = acc_q;
  assign reg_rdata = rd ? rdata_mux : '0;
  assign interrupt = interrupt_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q       <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_off_q   <= '0;
      acc_wdata_q <= '0;
      acc_wstrb_q <= '0;
      top_q       <= TOP_IDLE;
      for (int i = 0; i < NumChannels; i++) ch_q[i] <= CH_IDLE;
      done_bit_q  <= 1'b0;
      ready_bit_q <= 1'b0;
      auto_q      <= 1'b0;
      gie_q       <= 1'b0;
      ier_q       <= '0;
      isr_q       <= '0;
      mask_q      <= '1;
      chan_done_q <= '0;
      run_count_q <= '0;
      interrupt_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_we_q    <= acc_we_d;
      acc_off_q   <= acc_off_d;
      acc_wdata_q <= acc_wdata_d;
      acc_wstrb_q <= acc_wstrb_d;
      top_q       <= top_d;
      for (int i = 0; i < NumChannels; i++) ch_q[i] <= ch_d[i];
      done_bit_q  <= done_bit_d;
      ready_bit_q <= ready_bit_d;
      auto_q      <= auto_d;
      gie_q       <= gie_d;
      ier_q       <= ier_d;
      isr_q       <= isr_d;
      mask_q      <= mask_d;
      chan_done_q <= chan_done_d;
      run_count_q <= run_count_d;
      interrupt_q <= interrupt_d;
    end
  end

endmodule

// File: tb/tb_sda_kernel_ctrl_multi.sv
// tb/tb_sda_kernel_ctrl_multi.sv - directed vector bench for sda_kernel_ctrl_multi
module tb_sda_kernel_ctrl_multi;

  localparam int NCH = 4;

  logic           ap_clk;
  logic           ap_rst_n;
  logic           reg_req;
  logic           reg_ack;
  logic           reg_write_en;
  logic [6:0]     reg_addr;
  logic [31:0]    reg_wdata;
  logic [3:0]     reg_wstrb;
  logic [31:0]    reg_rdata;
  logic [NCH-1:0] go_valid;
  logic [NCH-1:0] go_stop;
  logic [NCH-1:0] done_valid;
  logic [NCH-1:0] done_stop;
  logic           interrupt;

  int total = 0;
  int bad   = 0;

  sda_kernel_ctrl_multi #(
    .NumChannels(NCH),
    .AddrWidth  (7),
    .BaseAddr   (0)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .reg_req     (reg_req),
    .reg_ack     (reg_ack),
    .reg_write_en(reg_write_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wstrb   (reg_wstrb),
    .reg_rdata   (reg_rdata),
    .go_valid    (go_valid),
    .go_stop     (go_stop),
    .done_valid  (done_valid),
    .done_stop   (done_stop),
    .interrupt   (interrupt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle.
  task automatic bus(input logic we, input logic [6:0] addr, input logic [31:0] wd,
                     input logic [3:0] ws, output logic ack, output logic [31:0] rd);
    reg_req      = 1'b1;
    reg_write_en = we;
    reg_addr     = addr;
    reg_wdata    = wd;
    reg_wstrb    = ws;
    @(negedge ap_clk);
    reg_req      = 1'b0;
    reg_write_en = 1'b0;
    ack          = reg_ack;
    rd           = reg_rdata;
  endtask

  task automatic wr(input string name, input logic [6:0] addr, input logic [31:0] wd);
    logic        ak;
    logic [31:0] r;
    bus(1'b1, addr, wd, 4'hF, ak, r);
    check(name, {31'd0, ak}, 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] addr, input logic [31:0] exp);
    logic        ak;
    logic [31:0] r;
    bus(1'b0, addr, 32'd0, 4'h0, ak, r);
    check(name, r, exp);
  endtask

  task automatic pulse_done(input logic [NCH-1:0] m);
    done_valid = m;
    @(negedge ap_clk);
    done_valid = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  initial begin
    ap_rst_n     = 1'b0;
    reg_req      = 1'b0;
    reg_write_en = 1'b0;
    reg_addr     = '0;
    reg_wdata    = '0;
    reg_wstrb    = '0;
    go_stop      = '0;
    done_valid   = '0;

    //              we    addr   wdata          wstrb  ack   rdata
    vecs.push_back('{1'b0, 7'h00, 32'h0,         4'h0, 1'b1, 32'h4});
    vecs.push_back('{1'b0, 7'h04, 32'h0,         4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h08, 32'h0,         4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h0C, 32'h0,         4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h10, 32'h0,         4'h0, 1'b1, 32'hF});
    vecs.push_back('{1'b0, 7'h14, 32'h0,         4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h18, 32'h0,         4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h1C, 32'h0,         4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 7'h04, 32'h1,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h04, 32'h0,         4'h0, 1'b1, 32'h1});
    vecs.push_back('{1'b1, 7'h08, 32'hFFFFFFFF,  4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h08, 32'h0,         4'h0, 1'b1, 32'h3});
    vecs.push_back('{1'b1, 7'h08, 32'h0,         4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h08, 32'h0,         4'h0, 1'b1, 32'h3});
    vecs.push_back('{1'b1, 7'h10, 32'h0000000A,  4'h1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h10, 32'h0,         4'h0, 1'b1, 32'hA});
    vecs.push_back('{1'b1, 7'h10, 32'hFFFFFF00,  4'hE, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h10, 32'h0,         4'h0, 1'b1, 32'hA});
    vecs.push_back('{1'b1, 7'h0C, 32'h3,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h0C, 32'h0,         4'h0, 1'b1, 32'h3});
    vecs.push_back('{1'b1, 7'h0C, 32'h2,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h0C, 32'h0,         4'h0, 1'b1, 32'h1});
    vecs.push_back('{1'b1, 7'h0C, 32'h1,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h0C, 32'h0,         4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h20, 32'h0,         4'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 7'h24, 32'h1,         4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 7'h10, 32'hF,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h10, 32'h0,         4'h0, 1'b1, 32'hF});
    vecs.push_back('{1'b1, 7'h04, 32'h0,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 7'h08, 32'h0,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 7'h00, 32'h80,        4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h00, 32'h0,         4'h0, 1'b1, 32'h84});
    vecs.push_back('{1'b1, 7'h00, 32'h0,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 7'h00, 32'h0,         4'h0, 1'b1, 32'h4});

    tick(3);
    check("rst_go_valid",  {28'd0, go_valid},  32'h0);
    check("rst_done_stop", {28'd0, done_stop}, 32'hF);
    check("rst_interrupt", {31'd0, interrupt}, 32'h0);
    check("rst_ack",       {31'd0, reg_ack},   32'h0);
    check("rst_rdata",     reg_rdata,          32'h0);
    ap_rst_n = 1'b1;
    tick(1);

    for (int i = 0; i < vecs.size(); i++) begin
      logic        ak;
      logic [31:0] r;
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, ak, r);
      check($sformatf("vec%0d_ack", i), {31'd0, ak}, {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
    end

    // Single run, dones in order 3,0,2,1.
    wr("s1_start", 7'h00, 32'h1);
    check("s1_go_pre", {28'd0, go_valid}, 32'h0);
    tick(1);
    check("s1_go", {28'd0, go_valid}, 32'hF);
    tick(1);
    check("s1_busy_stop", {28'd0, done_stop}, 32'h0);
    pulse_done(4'b1000);
    rd_chk("s1_ctrl_run", 7'h00, 32'h9);
    pulse_done(4'b0001);
    tick(1);
    pulse_done(4'b0100);
    pulse_done(4'b0010);
    rd_chk("s1_ctrl_done", 7'h00, 32'h6);
    rd_chk("s1_ctrl_cor", 7'h00, 32'h4);
    rd_chk("s1_chan_done", 7'h14, 32'hF);
    rd_chk("s1_count", 7'h18, 32'd1);
    check("s1_idle_stop", {28'd0, done_stop}, 32'hF);

    // Mask 0x5.
    wr("s2_mask", 7'h10, 32'h5);
    wr("s2_start", 7'h00, 32'h1);
    tick(1);
    check("s2_go", {28'd0, go_valid}, 32'h5);
    tick(1);
    check("s2_stop", {28'd0, done_stop}, 32'hA);
    pulse_done(4'b0001);
    rd_chk("s2_ctrl_run", 7'h00, 32'h9);
    pulse_done(4'b0100);
    rd_chk("s2_ctrl_done", 7'h00, 32'h6);
    rd_chk("s2_chan_done", 7'h14, 32'h5);
    rd_chk("s2_count", 7'h18, 32'd2);

    // Mask 0: completes with no channel; CTRL read coincides with COMPLETE.
    wr("s2z_mask", 7'h10, 32'h0);
    wr("s2z_start", 7'h00, 32'h1);
    tick(1);
    check("s2z_go", {28'd0, go_valid}, 32'h0);
    rd_chk("s2z_ctrl_same", 7'h00, 32'h9);
    rd_chk("s2z_ctrl_done", 7'h00, 32'h6);
    rd_chk("s2z_ctrl_cor", 7'h00, 32'h4);
    rd_chk("s2z_count", 7'h18, 32'd3);

    // Backpressure on channels 0..2; stray done on idle channel 3.
    wr("s3_mask", 7'h10, 32'h7);
    go_stop    = 4'hF;
    done_valid = 4'h8;
    wr("s3_start", 7'h00, 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check($sformatf("s3_go_hold%0d", k), {28'd0, go_valid}, 32'h7);
      check($sformatf("s3_stop%0d", k), {28'd0, done_stop}, 32'hF);
    end
    tick(1);
    check("s3_go_last", {28'd0, go_valid}, 32'h7);
    go_stop = '0;
    tick(1);
    check("s3_go_acc", {28'd0, go_valid}, 32'h0);
    check("s3_stop_busy", {28'd0, done_stop}, 32'h8);
    done_valid = '0;
    pulse_done(4'b0111);
    rd_chk("s3_ctrl", 7'h00, 32'hE);
    rd_chk("s3_chan_done", 7'h14, 32'h7);
    wr("s3_mask_rst", 7'h10, 32'hF);

    // Interrupt.
    wr("s4_isr_clr", 7'h0C, 32'h3);
    rd_chk("s4_isr0", 7'h0C, 32'h0);
    wr("s4_gie", 7'h04, 32'h1);
    wr("s4_ier", 7'h08, 32'h1);
    tick(1);
    check("s4_int_pre", {31'd0, interrupt}, 32'h0);
    wr("s4_start", 7'h00, 32'h1);
    tick(2);
    pulse_done(4'hF);
    check("s4_int_c1", {31'd0, interrupt}, 32'h0);
    tick(1);
    check("s4_int_c2", {31'd0, interrupt}, 32'h0);
    tick(1);
    check("s4_int_c3", {31'd0, interrupt}, 32'h1);
    wr("s4_isr_ack", 7'h0C, 32'h1);
    check("s4_int_a1", {31'd0, interrupt}, 32'h1);
    tick(1);
    check("s4_int_a2", {31'd0, interrupt}, 32'h1);
    tick(1);
    check("s4_int_a3", {31'd0, interrupt}, 32'h0);
    wr("s4_isr_set", 7'h0C, 32'h1);
    wr("s4_start2", 7'h00, 32'h1);
    tick(2);
    done_valid   = 4'hF;
    reg_req      = 1'b1;
    reg_write_en = 1'b1;
    reg_addr     = 7'h0C;
    reg_wdata    = 32'h1;
    reg_wstrb    = 4'hF;
    tick(1);
    done_valid   = '0;
    reg_req      = 1'b0;
    reg_write_en = 1'b0;
    check("s4_coinc_ack", {31'd0, reg_ack}, 32'h1);
    rd_chk("s4_isr_coinc", 7'h0C, 32'h3);
    wr("s4_isr_clr2", 7'h0C, 32'h3);
    wr("s4_gie_off", 7'h04, 32'h0);
    wr("s4_ier_off", 7'h08, 32'h0);
    rd_chk("s4_count", 7'h18, 32'd6);

    // Auto-restart.
    wr("s5_start", 7'h00, 32'h81);
    tick(1);
    check("s5_go0", {28'd0, go_valid}, 32'hF);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      pulse_done(4'hF);
      check($sformatf("s5_gap%0d", k), {28'd0, go_valid}, 32'h0);
      tick(1);
      check($sformatf("s5_restart%0d", k), {28'd0, go_valid}, 32'hF);
    end
    rd_chk("s5_count3", 7'h18, 32'd9);
    wr("s5_stop_auto", 7'h00, 32'h0);
    pulse_done(4'hF);
    tick(2);
    check("s5_go_idle", {28'd0, go_valid}, 32'h0);
    rd_chk("s5_ctrl", 7'h00, 32'hE);
    rd_chk("s5_count4", 7'h18, 32'd10);

    // Counter wrap.
    force dut.run_count_q = 32'hFFFF_FFFF;
    tick(1);
    release dut.run_count_q;
    rd_chk("s5_count_pre", 7'h18, 32'hFFFF_FFFF);
    wr("s5_wrap_start", 7'h00, 32'h1);
    tick(2);
    pulse_done(4'hF);
    tick(1);
    rd_chk("s5_count_wrap", 7'h18, 32'h0);

    // Reset mid-run with channels 2 and 3 busy.
    wr("s6_gie", 7'h04, 32'h1);
    wr("s6_ier", 7'h08, 32'h1);
    tick(2);
    check("s6_int_pre", {31'd0, interrupt}, 32'h1);
    wr("s6_start", 7'h00, 32'h1);
    tick(2);
    pulse_done(4'b0011);
    check("s6_stop_pre", {28'd0, done_stop}, 32'h3);
    ap_rst_n = 1'b0;
    tick(1);
    check("s6_go",    {28'd0, go_valid},  32'h0);
    check("s6_stop",  {28'd0, done_stop}, 32'hF);
    check("s6_int",   {31'd0, interrupt}, 32'h0);
    check("s6_ack",   {31'd0, reg_ack},   32'h0);
    check("s6_rdata", reg_rdata,          32'h0);
    ap_rst_n = 1'b1;
    tick(1);
    rd_chk("s6_ctrl",  7'h00, 32'h4);
    rd_chk("s6_count", 7'h18, 32'h0);
    rd_chk("s6_cdone", 7'h14, 32'h0);
    rd_chk("s6_mask",  7'h10, 32'hF);
    rd_chk("s6_isr",   7'h0C, 32'h0);
    tick(3);
    check("s6_go_after", {28'd0, go_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sda_kernel_ctrl_multi.md
# sda_kernel_ctrl_multi

Multi-channel successor to the single-action kernel control register block. It maps the SDAccel run/status programming interface onto NumChannels independent action run/done SELF handshakes, and adds a channel participation mask, auto-restart, per-channel completion status and a completed-run counter. It sits on the wrapper's simple register bus behind the AXI slave register selector, in parallel with the kernel argument memory. Acks and read data are OR-combined with the other register clients.

## Interface
Parameters:
- NumChannels, 1, number of action channels (1..32)
- AddrWidth, 7, width of reg_addr (byte address)
- BaseAddr, 0, byte offset of the 32-byte register window (32-byte aligned)

Ports:
- ap_clk  in  1  clock; the only clock
- ap_rst_n  in  1  reset; synchronous, active-low
- reg_req  in  1  register access strobe (one cycle)
- reg_ack  out  1  access acknowledge
- reg_write_en  in  1  1 = write, 0 = read
- reg_addr  in  AddrWidth  byte address
- reg_wdata  in  32  write data
- reg_wstrb  in  4  byte enables
- reg_rdata  out  32  read data; zero when not acking
- go_valid  out  NumChannels  per-channel run request
- go_stop  in  NumChannels  per-channel run backpressure (1 = not accepted)
- done_valid  in  NumChannels  per-channel completion
- done_stop  out  NumChannels  per-channel completion backpressure
- interrupt  out  1  level interrupt

## Operation
Registers are at BaseAddr plus the offsets below. Accesses outside the window produce no ack and reg_rdata = 0.
- 0x00 CTRL
  - bit0 START: write 1 launches a run when idle; reads 1 while running.
  - bit1 DONE: read-only, clear-on-read.
  - bit2 IDLE: read-only.
  - bit3 READY: read-only, clear-on-read; set on the launch cycle.
  - bit7 AUTO_RESTART: read/write.
- 0x04 GIE: bit0 global interrupt enable.
- 0x08 IER: bit0 done enable, bit1 ready enable.
- 0x0C ISR: bit0 done, bit1 ready. Writing 1 to a bit toggles it.
- 0x10 CHAN_MASK: participating channels. Resets to all ones (NumChannels bits).
- 0x14 CHAN_DONE: read-only; channels completed in the current or last run.
- 0x18 RUN_COUNT: read-only, 32-bit count of completed runs, wraps at 2^32.
- 0x1C: reserved; reads 0.

Write rules:
- Byte lanes with wstrb = 0 are not written.
- Unimplemented bits read 0.
- CHAN_MASK writes while running are acked and discarded.
- START writes while running are ignored.

Top FSM:
- IDLE -> RUN on START written or a pending auto-restart. CHAN_DONE clears and READY sets in the same cycle.
- RUN -> COMPLETE when every masked channel has finished.
- COMPLETE (one cycle): set DONE and ISR.done, increment RUN_COUNT. Then go to RUN if AUTO_RESTART = 1, otherwise IDLE.

Per-channel FSM:
- CH_IDLE -> CH_GO on launch if the channel's mask bit is 1.
- CH_GO: go_valid = 1. Moves to CH_BUSY on the cycle go_stop = 0.
- CH_BUSY: done_stop = 0. Moves to CH_DONE on done_valid = 1, which sets the channel's CHAN_DONE bit.
- CH_DONE: waits in CH_DONE until the top FSM leaves RUN, then returns to CH_IDLE.
- done_stop = 1 in all states other than CH_BUSY. A stray done on a non-busy channel stays stalled.

Boundary cases:
- Mask = 0 at launch: RUN completes on the next cycle.
- DONE set and CTRL read in the same cycle: the read returns DONE = 0 and DONE remains set.
- ISR hardware set and a toggle write on the same bit in the same cycle: the bit ends 1.
- interrupt = GIE.bit0 & |(IER & ISR), registered.

Reset: all FSMs idle and all registers at their reset values mid-operation. In-flight runs are abandoned; no done is reported.

## Timing
- reg_ack is a single-cycle pulse one cycle after reg_req. reg_rdata is valid in the same cycle as ack.
- Register writes take effect the cycle after ack.
- Launch to go_valid: go_valid rises one cycle after the START write is acked.
- Completion: the DONE bit is readable two cycles after the last done_valid is accepted.
- Interrupt: rises three cycles after the last done_valid is accepted.
- Auto-restart: go_valid reasserts two cycles after the last done_valid is accepted.
- Reset values:
  - reg_ack = 0, reg_rdata = 0
  - go_valid = 0, done_stop = all ones
  - interrupt = 0
  - IDLE = 1, all other registers 0 except CHAN_MASK

## Test plan
- Single run: NumChannels = 4; write CTRL = 1; hold go_stop = 0; pulse done_valid on channels 3, 0, 2, 1 at different cycles. Required: CHAN_DONE = 0xF, CTRL reads 0x6 then 0x4, RUN_COUNT = 1.
- Mask: CHAN_MASK = 0x5, start. Required: go_valid asserts only on channels 0 and 2; completion needs only those two done pulses. Repeat with mask = 0: DONE is set two cycles after the start write ack.
- Backpressure: go_stop = 1 for 10 cycles. Required: go_valid held for all 10 cycles and accepted on the first cycle go_stop = 0. A done_valid on an idle channel sees done_stop = 1 throughout.
- Interrupt: GIE = 1, IER = 1, run to completion. Required: interrupt = 1. Write ISR = 1: interrupt falls the cycle after the write takes effect. Also force a toggle write coincident with COMPLETE: ISR.done ends 1.
- Auto-restart: CTRL = 0x81, run three completions. Required: RUN_COUNT = 3 and go_valid re-asserted each time. Write CTRL = 0x00: the current run finishes, the FSM goes to IDLE and RUN_COUNT = 4. Preload RUN_COUNT = 0xFFFFFFFF via a test force: it wraps to 0.
- Reset mid-run: deassert ap_rst_n while two channels are busy. Required: all outputs at reset values the following cycle, IDLE = 1, no DONE.
